// File: rtl/bits_recorder_if.sv
// Bus between the change recorder and its environment: the recording
// controls and bus under observation, plus the valid/ready drain port.
interface bits_recorder_if #(
    parameter int WIDTH    = 4,
    parameter int TS_WIDTH = 32,
    parameter int DEPTH    = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                      enable_i;
    logic [WIDTH-1:0]          bits_i;
    logic                      rd_ready_i;
    logic [TS_WIDTH+WIDTH-1:0] data_o;
    logic                      valid_o;
    logic [CW-1:0]             count_o;
    logic                      overflow_o;

    // Environment side: drives the bus, enable and drain-ready.
    modport master (
        output enable_i, bits_i, rd_ready_i,
        input  data_o, valid_o, count_o, overflow_o
    );

    // Recorder side.
    modport slave (
        input  enable_i, bits_i, rd_ready_i,
        output data_o, valid_o, count_o, overflow_o
    );
endinterface

// File: rtl/bits_recorder.sv
// Timestamped change recorder: while enabled, logs {timestamp, value} on arm
// and on every change of bits_i into a FIFO drained via valid/ready.
module bits_recorder #(
    parameter int WIDTH    = 4,
    parameter int TS_WIDTH = 32,
    parameter int DEPTH    = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    bits_recorder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = TS_WIDTH + WIDTH;

    typedef logic [EW-1:0] entry_t;

    entry_t              r_mem [DEPTH];
    logic [AW-1:0]       r_rd_ptr;
    logic [AW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;
    logic [TS_WIDTH-1:0] r_ts;
    logic [WIDTH-1:0]    r_prev;
    logic                r_en_hist;
    logic                r_valid;
    logic                r_overflow;
    entry_t              r_data;

    logic                w_arm;
    logic                w_rec;
    logic                w_change;
    logic                w_full;
    logic                w_pop;
    logic                w_wr_en;
    logic                w_drop;
    entry_t              w_entry;
    logic [AW-1:0]       w_wr_addr;
    logic [AW-1:0]       w_rd_next;
    logic [AW-1:0]       w_wr_next;
    logic [CW-1:0]       w_count_next;
    logic [TS_WIDTH-1:0] w_ts_next;
    logic                w_ovf_next;
    entry_t              w_head_next;

    // Next-state decode: arm flushes and writes the initial entry in one edge;
    // otherwise push on change, pop on handshake, drop on full without pop.
    always_comb begin
        w_arm        = bus.enable_i & ~r_en_hist;
        w_rec        = bus.enable_i & r_en_hist;
        w_change     = w_rec & (bus.bits_i != r_prev);
        w_full       = (r_count == CW'(DEPTH));
        w_pop        = 1'b0;
        w_wr_en      = 1'b0;
        w_drop       = 1'b0;
        w_entry      = '0;
        w_wr_addr    = r_wr_ptr;
        w_rd_next    = r_rd_ptr;
        w_wr_next    = r_wr_ptr;
        w_count_next = r_count;
        w_ts_next    = r_ts;
        w_ovf_next   = r_overflow;
        if (w_arm) begin
            // Pending pops are irrelevant: the flush discards the old contents.
            w_wr_en      = 1'b1;
            w_entry      = {TS_WIDTH'(0), bus.bits_i};
            w_wr_addr    = '0;
            w_rd_next    = '0;
            w_wr_next    = AW'(1);
            w_count_next = CW'(1);
            w_ts_next    = TS_WIDTH'(1);
            w_ovf_next   = 1'b0;
        end else begin
            w_pop        = r_valid & bus.rd_ready_i;
            w_wr_en      = w_change & (~w_full | w_pop);
            w_drop       = w_change & w_full & ~w_pop;
            w_entry      = {r_ts, bus.bits_i};
            w_wr_addr    = r_wr_ptr;
            w_rd_next    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
            w_wr_next    = w_wr_en ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
            w_count_next = r_count + CW'(w_wr_en) - CW'(w_pop);
            w_ts_next    = w_rec ? (r_ts + TS_WIDTH'(1)) : r_ts;
            w_ovf_next   = r_overflow | w_drop;
        end
    end

    // Head of the FIFO after this edge, so data_o can be a plain register.
    // The entry being written this edge may itself become the head.
    always_comb begin
        w_head_next = '0;
        if (w_count_next == '0) begin
            w_head_next = '0;
        end else if (w_wr_en && (w_wr_addr == w_rd_next)) begin
            w_head_next = w_entry;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // Entry storage; cleared on reset so no stale data is ever observable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_entry;
        end
    end

    // Control state, timestamp, history and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_prev     <= '0;
            r_en_hist  <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_data     <= '0;
        end else begin
            r_rd_ptr   <= w_rd_next;
            r_wr_ptr   <= w_wr_next;
            r_count    <= w_count_next;
            r_ts       <= w_ts_next;
            r_prev     <= bus.bits_i;
            r_en_hist  <= bus.enable_i;
            r_valid    <= (w_count_next != '0);
            r_overflow <= w_ovf_next;
            r_data     <= w_head_next;
        end
    end

    assign bus.data_o     = r_data;
    assign bus.valid_o    = r_valid;
    assign bus.count_o    = r_count;
    assign bus.overflow_o = r_overflow;
endmodule

// File: tb/tb_bits_recorder.sv
// Bench for bits_recorder: table-driven arm sequence, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
// A second instance with a 4-bit timestamp shares the stimulus to see wrap.
module tb_bits_recorder;
    localparam int WIDTH = 4;
    localparam int TS_W  = 32;
    localparam int TS_S  = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    bits_recorder_if #(.WIDTH(WIDTH), .TS_WIDTH(TS_W), .DEPTH(DEPTH)) bus_a ();
    bits_recorder_if #(.WIDTH(WIDTH), .TS_WIDTH(TS_S), .DEPTH(DEPTH)) bus_b ();

    assign bus_b.enable_i   = bus_a.enable_i;
    assign bus_b.bits_i     = bus_a.bits_i;
    assign bus_b.rd_ready_i = bus_a.rd_ready_i;

    bits_recorder #(.WIDTH(WIDTH), .TS_WIDTH(TS_W), .DEPTH(DEPTH)) dut_a (
        .clk_i(clk), .reset_i(rst), .bus(bus_a));
    bits_recorder #(.WIDTH(WIDTH), .TS_WIDTH(TS_S), .DEPTH(DEPTH)) dut_b (
        .clk_i(clk), .reset_i(rst), .bus(bus_b));

    // Reference model: a queue of recorded entries and the recording state.
    typedef struct packed { logic [31:0] ts; logic [3:0] v; } ent_t;
    ent_t        q[$];
    bit          m_hist;
    logic [3:0]  m_prev;
    logic [31:0] m_ts;
    bit          m_ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         en;
        logic [3:0] bits;
        bit         rdy;
        bit         ev;
        int         ec;
        bit         eo;
        logic [35:0] ed;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hist = 1'b0;
        m_prev = 4'h0;
        m_ts   = 32'd0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        bit en; logic [3:0] b; bit rdy; bit pop; bit push; int n;
        en = bus_a.enable_i; b = bus_a.bits_i; rdy = bus_a.rd_ready_i;
        if (en && !m_hist) begin
            q.delete();
            q.push_back('{ts: 32'd0, v: b});
            m_ts  = 32'd1;
            m_ovf = 1'b0;
        end else begin
            n    = q.size();
            pop  = (n > 0) && rdy;
            push = en && m_hist && (b != m_prev);
            if (pop) void'(q.pop_front());
            if (push) begin
                if (n < DEPTH || pop) q.push_back('{ts: m_ts, v: b});
                else m_ovf = 1'b1;
            end
            if (en && m_hist) m_ts = m_ts + 32'd1;
        end
        m_hist = en;
        m_prev = b;
    endtask

    task automatic model_check(string tag);
        logic [35:0] ea; logic [7:0] eb; int n;
        n = q.size(); ea = '0; eb = '0;
        if (n > 0) begin
            ea = q[0];
            eb = {q[0].ts[3:0], q[0].v};
        end
        chk({tag, ".valid"}, 64'(bus_a.valid_o), 64'(n > 0));
        chk({tag, ".count"}, 64'(bus_a.count_o), 64'(n));
        chk({tag, ".ovf"},   64'(bus_a.overflow_o), 64'(m_ovf));
        chk({tag, ".data"},  64'(bus_a.data_o), 64'(ea));
        chk({tag, ".b_cnt"}, 64'(bus_b.count_o), 64'(n));
        chk({tag, ".b_data"}, 64'(bus_b.data_o), 64'(eb));
    endtask

    task automatic drive(bit en, logic [3:0] b, bit rdy);
        bus_a.enable_i   = en;
        bus_a.bits_i     = b;
        bus_a.rd_ready_i = rdy;
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        model_check(tag);
    endtask

    // Stimulus sequence.
    initial begin
        tbl[0] = '{1'b1, 4'h0, 1'b1, 1'b1, 1, 1'b0, {32'd0, 4'h0}};
        tbl[1] = '{1'b1, 4'h0, 1'b1, 1'b0, 0, 1'b0, 36'd0};
        tbl[2] = '{1'b1, 4'h0, 1'b1, 1'b0, 0, 1'b0, 36'd0};
        tbl[3] = '{1'b1, 4'h1, 1'b1, 1'b1, 1, 1'b0, {32'd3, 4'h1}};
        tbl[4] = '{1'b1, 4'h1, 1'b1, 1'b0, 0, 1'b0, 36'd0};
        tbl[5] = '{1'b1, 4'h3, 1'b1, 1'b1, 1, 1'b0, {32'd5, 4'h3}};
        tbl[6] = '{1'b1, 4'h3, 1'b1, 1'b0, 0, 1'b0, 36'd0};
        tbl[7] = '{1'b1, 4'h3, 1'b1, 1'b0, 0, 1'b0, 36'd0};

        drive(1'b0, 4'h0, 1'b0);
        model_reset();
        #12;
        chk("rst.valid", 64'(bus_a.valid_o), 64'd0);
        chk("rst.count", 64'(bus_a.count_o), 64'd0);
        chk("rst.ovf",   64'(bus_a.overflow_o), 64'd0);
        chk("rst.data",  64'(bus_a.data_o), 64'd0);
        rst = 1'b0;

        // Arm and toggle: idle edges then the table.
        for (int i = 0; i < 9; i++) step("idle");
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].en, tbl[i].bits, tbl[i].rdy);
            step("tbl");
            chk($sformatf("tbl%0d.valid", i), 64'(bus_a.valid_o), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.count", i), 64'(bus_a.count_o), 64'(tbl[i].ec));
            chk($sformatf("tbl%0d.ovf", i),   64'(bus_a.overflow_o), 64'(tbl[i].eo));
            chk($sformatf("tbl%0d.data", i),  64'(bus_a.data_o), 64'(tbl[i].ed));
        end

        // Backpressure and overflow.
        drive(1'b0, 4'h0, 1'b0); step("ovf.dis");
        drive(1'b1, 4'h0, 1'b0); step("ovf.arm");
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 4'(k & 1), 1'b0);
            step("ovf.fill");
        end
        chk("ovf.count16", 64'(bus_a.count_o), 64'd16);
        chk("ovf.flag",    64'(bus_a.overflow_o), 64'd1);
        drive(1'b1, 4'h0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf.drain%0d", i), 64'(bus_a.data_o), 64'({32'(i), 4'(i & 1)}));
            step("ovf.drain");
        end
        chk("ovf.empty", 64'(bus_a.valid_o), 64'd0);
        chk("ovf.sticky", 64'(bus_a.overflow_o), 64'd1);

        // Disarm / re-arm.
        drive(1'b1, 4'h1, 1'b0); step("rearm.rec");
        drive(1'b1, 4'h2, 1'b0); step("rearm.rec");
        drive(1'b1, 4'h3, 1'b0); step("rearm.rec");
        chk("rearm.count3", 64'(bus_a.count_o), 64'd3);
        drive(1'b0, 4'h5, 1'b0); step("rearm.off");
        drive(1'b0, 4'h6, 1'b0); step("rearm.off");
        chk("rearm.hold3", 64'(bus_a.count_o), 64'd3);
        drive(1'b1, 4'b1010, 1'b0); step("rearm.arm");
        chk("rearm.count1", 64'(bus_a.count_o), 64'd1);
        chk("rearm.data",   64'(bus_a.data_o), 64'({32'd0, 4'b1010}));
        chk("rearm.ovf",    64'(bus_a.overflow_o), 64'd0);

        // Full with simultaneous pop.
        for (int k = 1; k <= 15; k++) begin
            drive(1'b1, (k & 1) ? 4'b0101 : 4'b1010, 1'b0);
            step("full.fill");
        end
        chk("full.count16", 64'(bus_a.count_o), 64'd16);
        drive(1'b1, 4'b1010, 1'b1); step("full.pushpop");
        chk("full.keep16", 64'(bus_a.count_o), 64'd16);
        chk("full.noovf",  64'(bus_a.overflow_o), 64'd0);
        drive(1'b0, 4'b1010, 1'b1);
        for (int i = 0; i < 15; i++) step("full.drain");
        chk("full.tail", 64'(bus_a.data_o), 64'({32'd16, 4'b1010}));
        step("full.last");
        chk("full.empty", 64'(bus_a.valid_o), 64'd0);

        // Async reset with 5 entries queued.
        drive(1'b1, 4'h0, 1'b0); step("ar.arm");
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 4'(k), 1'b0);
            step("ar.rec");
        end
        chk("ar.count5", 64'(bus_a.count_o), 64'd5);
        #3;
        drive(1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("ar.valid", 64'(bus_a.valid_o), 64'd0);
        chk("ar.count", 64'(bus_a.count_o), 64'd0);
        chk("ar.ovf",   64'(bus_a.overflow_o), 64'd0);
        chk("ar.data",  64'(bus_a.data_o), 64'd0);
        model_reset();
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 4'(k + 5), 1'b0);
            step("ar.idle");
        end
        chk("ar.noarm", 64'(bus_a.count_o), 64'd0);
        drive(1'b1, 4'h3, 1'b0); step("ar.rearm");
        chk("ar.rearm", 64'(bus_a.data_o), 64'({32'd0, 4'h3}));

        // Timestamp wrap on the 4-bit instance.
        drive(1'b0, 4'h3, 1'b1); step("wrap.drain");
        step("wrap.drain");
        drive(1'b1, 4'h0, 1'b0); step("wrap.arm");
        for (int i = 0; i < 14; i++) step("wrap.wait");
        drive(1'b1, 4'h1, 1'b0); step("wrap.ch15");
        drive(1'b1, 4'h0, 1'b0); step("wrap.ch0");
        chk("wrap.count", 64'(bus_b.count_o), 64'd3);
        drive(1'b0, 4'h0, 1'b1);
        step("wrap.pop");
        chk("wrap.b15", 64'(bus_b.data_o), 64'({4'd15, 4'h1}));
        chk("wrap.a15", 64'(bus_a.data_o), 64'({32'd15, 4'h1}));
        step("wrap.pop");
        chk("wrap.b0",  64'(bus_b.data_o), 64'({4'd0, 4'h0}));
        chk("wrap.a16", 64'(bus_a.data_o), 64'({32'd16, 4'h0}));
        step("wrap.pop");

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bit en_r; bit rdy_r; logic [3:0] b_r;
            en_r  = ($urandom_range(0, 29) != 0);
            b_r   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : bus_a.bits_i;
            rdy_r = ((i % 600) < 300) ? ($urandom_range(0, 9) == 0)
                                      : ($urandom_range(0, 3) != 0);
            drive(en_r, b_r, rdy_r);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
